// File: rtl/apb_master_arbiter_pkg.sv
// Shared definitions for the two-requester APB master arbiter.
//   state_t         : transfer FSM states
//   ADDR_W/DATA_W/STRB_W : APB field widths
//   TIMEOUT_DEFAULT : default ACCESS wait-state limit
package apb_master_arbiter_pkg;

    localparam int unsigned ADDR_W          = 8;
    localparam int unsigned DATA_W          = 32;
    localparam int unsigned STRB_W          = 4;
    localparam int unsigned TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess
    } state_t;

endpackage

// File: rtl/apb_master_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter.
// Ports:
//   PCLK, PRESET : clock, asynchronous active-high reset
//   req[1:0]     : request lines
//   advance      : a grant is being taken this cycle; update the pointer
//   grant[1:0]   : one-hot grant (zero when no request)
module rr_arbiter2 (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // Index of the requester granted most recently. Resets to 1 so that
    // requester 0 wins the first contention.
    logic last_q;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            last_q <= 1'b1;
        end else if (advance) begin
            last_q <= grant[1];
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB master shared by two requesters with round-robin arbitration and a
// wait-state timeout.
// Ports:
//   PCLK, PRESET                     : clock, asynchronous active-high reset
//   req_valid/req_ready              : per-requester handshake (ready is a
//                                      one-cycle pulse in the IDLE grant cycle)
//   req_write/addr/wdata/strb        : per-requester command fields
//   rsp_valid/rsp_rdata/rsp_err      : one-cycle completion pulse and result
//   PSEL..PSTRB                      : registered APB master outputs
//   PRDATA/PREADY/PSLVERR            : APB slave response
module apb_master_arbiter
    import apb_master_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    parameter int unsigned NREQ    = 2
) (
    input  logic                           PCLK,
    input  logic                           PRESET,
    input  logic [NREQ-1:0]                req_valid,
    output logic [NREQ-1:0]                req_ready,
    input  logic [NREQ-1:0]                req_write,
    input  logic [NREQ-1:0][ADDR_W-1:0]    req_addr,
    input  logic [NREQ-1:0][DATA_W-1:0]    req_wdata,
    input  logic [NREQ-1:0][STRB_W-1:0]    req_strb,
    output logic [NREQ-1:0]                rsp_valid,
    output logic [DATA_W-1:0]              rsp_rdata,
    output logic                           rsp_err,
    output logic                           PSEL,
    output logic                           PENABLE,
    output logic                           PWRITE,
    output logic [ADDR_W-1:0]              PADDR,
    output logic [DATA_W-1:0]              PWDATA,
    output logic [STRB_W-1:0]              PSTRB,
    input  logic [DATA_W-1:0]              PRDATA,
    input  logic                           PREADY,
    input  logic                           PSLVERR
);

    // Abort fires in the TIMEOUT-th ACCESS cycle that still sees PREADY low.
    localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

    state_t     state_q;
    logic       owner_q;   // requester that owns the current transfer
    logic [7:0] wait_q;    // ACCESS cycles elapsed with PREADY low
    logic [1:0] grant;
    logic       advance;
    logic       gsel;

    assign advance = (state_q == StIdle) && (|req_valid);
    assign gsel    = grant[1];

    // Acceptance is signalled in the IDLE cycle itself so that a requester
    // sees req_ready exactly while its command is being latched.
    assign req_ready = (advance && !PRESET) ? grant : '0;

    rr_arbiter2 u_arb (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .req     (req_valid),
        .advance (advance),
        .grant   (grant)
    );

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= StIdle;
            owner_q   <= 1'b0;
            wait_q    <= '0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            PSTRB     <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= '0;
            case (state_q)
                StIdle: begin
                    if (advance) begin
                        owner_q <= gsel;
                        PSEL    <= 1'b1;
                        PENABLE <= 1'b0;
                        PWRITE  <= req_write[gsel];
                        PADDR   <= req_addr[gsel];
                        // Reads drive no data and no strobes.
                        PWDATA  <= req_write[gsel] ? req_wdata[gsel] : '0;
                        PSTRB   <= req_write[gsel] ? req_strb[gsel] : '0;
                        state_q <= StSetup;
                    end
                end
                StSetup: begin
                    PENABLE <= 1'b1;
                    wait_q  <= '0;
                    state_q <= StAccess;
                end
                StAccess: begin
                    // PREADY wins over the timeout when both land together.
                    if (PREADY) begin
                        rsp_valid[owner_q] <= 1'b1;
                        rsp_rdata          <= PWRITE ? '0 : PRDATA;
                        rsp_err            <= PSLVERR;
                        PSEL               <= 1'b0;
                        PENABLE            <= 1'b0;
                        state_q            <= StIdle;
                    end else if (wait_q == WaitLast) begin
                        rsp_valid[owner_q] <= 1'b1;
                        rsp_rdata          <= '0;
                        rsp_err            <= 1'b1;
                        PSEL               <= 1'b0;
                        PENABLE            <= 1'b0;
                        state_q            <= StIdle;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
module tb_apb_master_arbiter;

    logic             PCLK = 1'b0;
    logic             PRESET;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       req_write;
    logic [1:0][7:0]  req_addr;
    logic [1:0][31:0] req_wdata;
    logic [1:0][3:0]  req_strb;
    logic [1:0]       rsp_valid;
    logic [31:0]      rsp_rdata;
    logic             rsp_err;
    logic             PSEL, PENABLE, PWRITE;
    logic [7:0]       PADDR;
    logic [31:0]      PWDATA;
    logic [3:0]       PSTRB;
    logic [31:0]      PRDATA;
    logic             PREADY, PSLVERR;

    int total = 0;
    int bad   = 0;

    apb_master_arbiter #(.TIMEOUT(16), .NREQ(2)) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_strb  (req_strb),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PSTRB     (PSTRB),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic step;
        @(posedge PCLK);
        #1;
    endtask

    task automatic set_cmd(input int i, input logic w, input logic [7:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        req_write[i] = w;
        req_addr[i]  = a;
        req_wdata[i] = d;
        req_strb[i]  = s;
    endtask

    task automatic test_reset;
        PRESET = 1'b1; req_valid = 2'b11; PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = '0;
        req_write = '0; req_addr = '0; req_wdata = '0; req_strb = '0;
        #3;
        total++;
        if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB} !== 47'd0) begin
            bad++; $display("FAIL reset_apb got=%h exp=0",
                            {PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB});
        end
        total++;
        if ({rsp_valid, rsp_rdata, rsp_err} !== 35'd0) begin
            bad++; $display("FAIL reset_rsp got=%h exp=0", {rsp_valid, rsp_rdata, rsp_err});
        end
        step; step;
        total++;
        if (req_ready !== 2'b00) begin
            bad++; $display("FAIL reset_ready got=%b exp=00", req_ready);
        end
        req_valid = 2'b00;
        PRESET = 1'b0;
        step;
    endtask

    task automatic test_single_write;
        set_cmd(0, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF);
        PREADY = 1'b1; req_valid = 2'b01;
        #1;
        total++;
        if (req_ready !== 2'b01) begin
            bad++; $display("FAIL wr_ready got=%b exp=01", req_ready);
        end
        step; req_valid = 2'b00;
        total++;
        if ({PSEL, PENABLE, req_ready} !== 4'b1000) begin
            bad++; $display("FAIL wr_setup got=%b exp=1000", {PSEL, PENABLE, req_ready});
        end
        total++;
        if ({PWRITE, PADDR, PWDATA, PSTRB} !== {1'b1, 8'h10, 32'hDEADBEEF, 4'hF}) begin
            bad++; $display("FAIL wr_setup_cmd got=%h", {PWRITE, PADDR, PWDATA, PSTRB});
        end
        step;
        total++;
        if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, rsp_valid}
            !== {2'b11, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 2'b00}) begin
            bad++; $display("FAIL wr_access got=%h",
                            {PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, rsp_valid});
        end
        step;
        total++;
        if ({rsp_valid, rsp_err, rsp_rdata, PSEL, PENABLE} !== {2'b01, 1'b0, 32'd0, 2'b00}) begin
            bad++; $display("FAIL wr_rsp got=%h exp=%h",
                            {rsp_valid, rsp_err, rsp_rdata, PSEL, PENABLE},
                            {2'b01, 1'b0, 32'd0, 2'b00});
        end
        step;
        total++;
        if (rsp_valid !== 2'b00) begin
            bad++; $display("FAIL wr_rsp_pulse got=%b exp=00", rsp_valid);
        end
    endtask

    task automatic test_read_wait;
        set_cmd(1, 1'b0, 8'h20, 32'hAAAA5555, 4'hF);
        PREADY = 1'b0; PRDATA = '0; req_valid = 2'b10;
        #1;
        total++;
        if (req_ready !== 2'b10) begin
            bad++; $display("FAIL rd_ready got=%b exp=10", req_ready);
        end
        step; req_valid = 2'b00;
        total++;
        if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB}
            !== {2'b10, 1'b0, 8'h20, 32'd0, 4'h0}) begin
            bad++; $display("FAIL rd_setup got=%h",
                            {PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB});
        end
        for (int i = 0; i < 4; i++) begin
            step;
            total++;
            if ({PSEL, PENABLE, PSTRB, PWDATA, rsp_valid} !== {2'b11, 4'h0, 32'd0, 2'b00}) begin
                bad++; $display("FAIL rd_wait%0d got=%h", i,
                                {PSEL, PENABLE, PSTRB, PWDATA, rsp_valid});
            end
        end
        // Fourth ACCESS cycle: slave now ready.
        PREADY = 1'b1; PRDATA = 32'h12345678;
        step;
        total++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 1'b0, 32'h12345678}) begin
            bad++; $display("FAIL rd_rsp got=%h exp=%h", {rsp_valid, rsp_err, rsp_rdata},
                            {2'b10, 1'b0, 32'h12345678});
        end
        PRDATA = '0;
    endtask

    task automatic test_contention;
        logic [1:0] exp;
        logic [7:0] exp_addr;
        set_cmd(0, 1'b1, 8'h30, 32'h11, 4'h3);
        set_cmd(1, 1'b1, 8'h31, 32'h22, 4'hC);
        PREADY = 1'b1; req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            exp      = (k % 2 == 1) ? 2'b10 : 2'b01;
            exp_addr = (k % 2 == 1) ? 8'h31 : 8'h30;
            #1;
            total++;
            if (req_ready !== exp) begin
                bad++; $display("FAIL cont_ready%0d got=%b exp=%b", k, req_ready, exp);
            end
            step;
            total++;
            if (PADDR !== exp_addr) begin
                bad++; $display("FAIL cont_addr%0d got=%h exp=%h", k, PADDR, exp_addr);
            end
            step; step;
            total++;
            if (rsp_valid !== exp) begin
                bad++; $display("FAIL cont_rsp%0d got=%b exp=%b", k, rsp_valid, exp);
            end
            if (k == 3) req_valid = 2'b00;
        end
        step;
        total++;
        if ({PSEL, req_ready} !== 3'b000) begin
            bad++; $display("FAIL cont_idle got=%b exp=000", {PSEL, req_ready});
        end
    endtask

    task automatic test_timeout;
        int  n;
        bit  done;
        set_cmd(0, 1'b0, 8'h40, 32'h0, 4'h0);
        PREADY = 1'b0; PRDATA = 32'hCAFEF00D; req_valid = 2'b01;
        #1;
        step; req_valid = 2'b00;
        n = 0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            step;
            if (PSEL && PENABLE) n++;
            else done = 1'b1;
        end
        total++;
        if (!done) begin
            bad++; $display("FAIL to_bound got=still_busy exp=abort");
        end
        total++;
        if (n !== 16) begin
            bad++; $display("FAIL to_cycles got=%0d exp=16", n);
        end
        total++;
        if ({rsp_valid, rsp_err, rsp_rdata, PSEL} !== {2'b01, 1'b1, 32'd0, 1'b0}) begin
            bad++; $display("FAIL to_rsp got=%h exp=%h", {rsp_valid, rsp_err, rsp_rdata, PSEL},
                            {2'b01, 1'b1, 32'd0, 1'b0});
        end
        PRDATA = '0;
    endtask

    task automatic test_timeout_edge;
        set_cmd(1, 1'b0, 8'h41, 32'h0, 4'h0);
        PREADY = 1'b0; PRDATA = 32'h0BADC0DE; req_valid = 2'b10;
        #1;
        step; req_valid = 2'b00;
        repeat (16) step;
        // Sixteenth ACCESS cycle: still busy, slave answers now.
        total++;
        if ({PSEL, PENABLE, rsp_valid} !== 4'b1100) begin
            bad++; $display("FAIL toe_still got=%b exp=1100", {PSEL, PENABLE, rsp_valid});
        end
        PREADY = 1'b1;
        step;
        total++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 1'b0, 32'h0BADC0DE}) begin
            bad++; $display("FAIL toe_rsp got=%h exp=%h", {rsp_valid, rsp_err, rsp_rdata},
                            {2'b10, 1'b0, 32'h0BADC0DE});
        end
        PRDATA = '0;
    endtask

    task automatic test_slverr;
        set_cmd(1, 1'b1, 8'hFF, 32'h5, 4'h1);
        PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'hFFFFFFFF; req_valid = 2'b10;
        #1;
        step; req_valid = 2'b00;
        total++;
        if ({PWRITE, PADDR} !== {1'b1, 8'hFF}) begin
            bad++; $display("FAIL err_cmd got=%h exp=1ff", {PWRITE, PADDR});
        end
        step; step;
        total++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 1'b1, 32'd0}) begin
            bad++; $display("FAIL err_rsp got=%h exp=%h", {rsp_valid, rsp_err, rsp_rdata},
                            {2'b10, 1'b1, 32'd0});
        end
        PSLVERR = 1'b0; PRDATA = '0;
    endtask

    task automatic test_reset_mid;
        set_cmd(0, 1'b0, 8'h50, 32'h0, 4'h0);
        PREADY = 1'b0; req_valid = 2'b01;
        #1;
        step; req_valid = 2'b00;
        step; step;
        #2 PRESET = 1'b1;
        #1;
        total++;
        if ({PSEL, PENABLE} !== 2'b00) begin
            bad++; $display("FAIL rst_mid_apb got=%b exp=00", {PSEL, PENABLE});
        end
        step;
        total++;
        if ({rsp_valid, req_ready} !== 4'b0000) begin
            bad++; $display("FAIL rst_mid_rsp got=%b exp=0000", {rsp_valid, req_ready});
        end
        PRESET = 1'b0;
        set_cmd(0, 1'b0, 8'h60, 32'h0, 4'h0);
        set_cmd(1, 1'b0, 8'h61, 32'h0, 4'h0);
        PREADY = 1'b1; req_valid = 2'b11;
        #1;
        total++;
        if (req_ready !== 2'b01) begin
            bad++; $display("FAIL rst_rr got=%b exp=01", req_ready);
        end
        step; req_valid = 2'b00;
        total++;
        if ({PSEL, PADDR, rsp_valid} !== {1'b1, 8'h60, 2'b00}) begin
            bad++; $display("FAIL rst_first_grant got=%h exp=%h", {PSEL, PADDR, rsp_valid},
                            {1'b1, 8'h60, 2'b00});
        end
        step; step;
        total++;
        if (rsp_valid !== 2'b01) begin
            bad++; $display("FAIL rst_after_rsp got=%b exp=01", rsp_valid);
        end
    endtask

    initial begin
        test_reset;
        test_single_write;
        test_read_wait;
        test_contention;
        test_timeout;
        test_timeout_edge;
        test_slverr;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/apb_master_arbiter.md
APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

Interface
REQ-001 SHALL expose parameter: TIMEOUT, 16, max ACCESS-phase cycles with PREADY low before abort (range 2..255).
REQ-002 SHALL expose parameter: NREQ, 2, number of requesters (fixed at 2 for this revision).
REQ-003 SHALL have ports: PCLK  in  1  bus clock, all logic on rising edge.
REQ-004 SHALL have ports: PRESET  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports: req_valid  in  2  per-requester transfer request, held until accepted.
REQ-006 SHALL have ports: req_ready  out  2  one-hot, one-cycle acceptance pulse.
REQ-007 SHALL have ports: req_write  in  2;  req_addr  in  2x8;  req_wdata  in  2x32;  req_strb  in  2x4 -- per-requester command fields.
REQ-008 SHALL have ports: rsp_valid  out  2  one-hot, one-cycle completion pulse.
REQ-009 SHALL have ports: rsp_rdata  out  32  read data, valid with rsp_valid; rsp_err  out  1  error flag, valid with rsp_valid.
REQ-010 SHALL have ports: PSEL, PENABLE, PWRITE  out  1;  PADDR  out  8;  PWDATA  out  32;  PSTRB  out  4  APB master outputs.
REQ-011 SHALL have ports: PRDATA  in  32;  PREADY  in  1;  PSLVERR  in  1  APB slave responses.

Function
REQ-012 SHALL implement FSM states IDLE, SETUP, ACCESS; all APB outputs registered.
REQ-013 IDLE: if any req_valid high, grant winner g, pulse req_ready[g] for one cycle, latch g's command, next state SETUP; else stay IDLE.
REQ-014 Arbitration SHALL be round-robin: on contention grant the requester not granted last; a lone requester always wins.
REQ-015 SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA/PSTRB = latched command; next state ACCESS unconditionally.
REQ-016 ACCESS: PSEL=1, PENABLE=1, all other APB outputs held stable from SETUP.
REQ-017 ACCESS with PREADY=1: capture PRDATA (reads) and PSLVERR; pulse rsp_valid[g] the next cycle; return to IDLE with PSEL=PENABLE=0.
REQ-018 For writes, rsp_rdata SHALL be 0; rsp_err SHALL equal captured PSLVERR.
REQ-019 For reads, PSTRB SHALL be 4'b0000 and PWDATA SHALL be 0 regardless of req_strb/req_wdata.
REQ-020 Wait-state counter SHALL clear on ACCESS entry and increment per ACCESS cycle with PREADY=0.
REQ-021 When counter reaches TIMEOUT with PREADY still 0: abort, rsp_valid[g]=1, rsp_err=1, rsp_rdata=0, return to IDLE.
REQ-022 PREADY=1 on the cycle the counter reaches TIMEOUT SHALL count as normal completion, not timeout.
REQ-023 Minimum transfer latency: req_ready to rsp_valid = 3 cycles; a new grant SHALL not occur before the IDLE cycle following completion.
REQ-024 req_valid changes outside IDLE SHALL be ignored; requests pending at completion compete in the next IDLE cycle.
REQ-025 PSEL SHALL never be high in IDLE; PENABLE SHALL never be high without PSEL.

Reset
REQ-026 PRESET high SHALL asynchronously force: state IDLE, PSEL=PENABLE=PWRITE=0, PADDR=0, PWDATA=0, PSTRB=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter 0.
REQ-027 Round-robin pointer SHALL reset so requester 0 wins first contention.
REQ-028 Reset mid-transfer SHALL abort the transfer with no rsp_valid pulse; first grant possible on the first PCLK edge after PRESET deasserts.

Structure
REQ-029 A shared package SHALL hold the FSM state enum, APB width constants (8/32/4) and the TIMEOUT default.
REQ-030 The round-robin arbiter SHALL be a sub-module rr_arbiter2 (req[1:0], advance -> one-hot grant), pointer updated on grant.

Verification
REQ-031 Single write: req0 write addr 0x10 data 0xDEADBEEF strb 0xF, PREADY=1 -> SETUP then ACCESS, rsp_valid[0] 3 cycles after req_ready[0], rsp_err=0.
REQ-032 Read with 3 wait states: req1 read addr 0x20, PREADY low 3 ACCESS cycles, PRDATA=0x12345678 -> rsp_rdata=0x12345678, PSTRB=0 throughout.
REQ-033 Contention: both req_valid held for 4 transfers -> grant order 0,1,0,1.
REQ-034 Timeout: PREADY held 0, TIMEOUT=16 -> abort after 16 ACCESS cycles, rsp_err=1, rsp_rdata=0, PSEL low next cycle.
REQ-035 Slave error: PSLVERR=1 with PREADY=1 on write addr 0xFF -> rsp_err=1.
REQ-036 Reset in ACCESS: PRESET asserted mid-wait -> PSEL/PENABLE 0 immediately, no rsp_valid, next grant to requester 0.
